// File: rtl/spi_alu_master_if.sv
// rtl/spi_alu_master_if.sv - SPI bus signals shared by the ALU master and its slave
interface spi_alu_master_if;
  logic sclk;
  logic mosi;
  logic nss;
  logic miso;

  modport MASTER (output sclk, output mosi, output nss, input miso);
  modport SLAVE  (input sclk, input mosi, input nss, output miso);
endinterface

// File: rtl/spi_alu_master.sv
// rtl/spi_alu_master.sv - SPI master sending {opcode, op_a, op_b} to an ALU slave and reading back a 32-bit result (optional abort: SPI_ALU_MASTER_ABORT_EN)
module spi_alu_master #(
  parameter int CLK_DIV = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
`ifdef SPI_ALU_MASTER_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  spi_alu_master_if.MASTER spi_if
);

  typedef enum logic [2:0] {IDLE, SETUP, SEND, GAP, RECV, FINISH} state_t;

  // Divider counts a whole sclk period (low half then high half) or a fixed hold.
  localparam int            DW         = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] HALF_END   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HIGH_START = DW'(CLK_DIV);
  localparam logic [DW-1:0] FULL_END   = DW'(2 * CLK_DIV - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [6:0]    bits, bits_nxt;
  logic [67:0]   tx_data;
  logic [31:0]   rx_data;
  logic          accept;
  logic          abort_hit;
  logic          busy_nxt, done_nxt, nss_nxt, sclk_nxt, mosi_nxt;

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_nxt = state;
    div_nxt   = div + 1'b1;
    bits_nxt  = bits;
    accept    = 1'b0;
    abort_hit = 1'b0;
    case (state)
      IDLE: begin
        div_nxt = '0;
        // done is high only in the first idle cycle, which blocks back-to-back starts
        if (start && !done) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div == HALF_END) begin
          state_nxt = SEND;
          div_nxt   = '0;
        end
      end
      SEND: begin
        if (div == FULL_END) begin
          div_nxt = '0;
          if (bits == 7'd67) begin
            state_nxt = GAP;
            bits_nxt  = '0;
          end else begin
            bits_nxt = bits + 7'd1;
          end
        end
      end
      GAP: begin
        if (div == FULL_END) begin
          state_nxt = RECV;
          div_nxt   = '0;
        end
      end
      RECV: begin
        if (div == FULL_END) begin
          div_nxt = '0;
          if (bits == 7'd31) begin
            state_nxt = FINISH;
            bits_nxt  = '0;
          end else begin
            bits_nxt = bits + 7'd1;
          end
        end
      end
      FINISH: begin
        if (div == HALF_END) begin
          state_nxt = IDLE;
          div_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        div_nxt   = '0;
        bits_nxt  = '0;
      end
    endcase
`ifdef SPI_ALU_MASTER_ABORT_EN
    if (abort && state != IDLE) begin
      abort_hit = 1'b1;
      state_nxt = IDLE;
      div_nxt   = '0;
      bits_nxt  = '0;
    end
`endif
    busy_nxt = (state_nxt != IDLE);
    nss_nxt  = (state_nxt == IDLE);
    sclk_nxt = ((state_nxt == SEND) || (state_nxt == RECV)) && (div_nxt >= HIGH_START);
    // mosi only moves when a new bit starts, which is always inside the low half
    mosi_nxt = (state_nxt == SEND) ? tx_data[7'd67 - bits_nxt] : 1'b0;
    done_nxt = (state == FINISH) && (state_nxt == IDLE) && !abort_hit;
  end

  // State and phase counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      div   <= '0;
      bits  <= '0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      bits  <= bits_nxt;
    end
  end

  // Request latch and receive shifter; miso is taken on the edge that raises sclk.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_data <= '0;
      rx_data <= '0;
    end else begin
      if (accept) begin
        tx_data <= {opcode, op_a, op_b};
      end
      if (state == RECV && div == HALF_END) begin
        rx_data <= {rx_data[30:0], spi_if.miso};
      end
    end
  end

  // Registered outputs, so the bus pins never glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      spi_if.nss  <= 1'b1;
      spi_if.sclk <= 1'b0;
      spi_if.mosi <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      done        <= done_nxt;
      spi_if.nss  <= nss_nxt;
      spi_if.sclk <= sclk_nxt;
      spi_if.mosi <= mosi_nxt;
      if (done_nxt) begin
        result <= rx_data;
      end
    end
  end

`ifdef SPI_ALU_MASTER_ABORT_EN
  // One-cycle indication that a transfer was dropped on request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`endif

endmodule

// File: tb/tb_spi_alu_master.sv
// tb/tb_spi_alu_master.sv - directed vector bench for spi_alu_master with a behavioural ALU slave
module tb_spi_alu_master;

  localparam int CLK_DIV = 4;
  localparam int TXN_LEN = CLK_DIV * (1 + 2 * 68 + 2 + 2 * 32 + 1);

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef SPI_ALU_MASTER_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  spi_alu_master_if bus ();

  spi_alu_master #(.CLK_DIV(CLK_DIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .opcode  (opcode),
    .op_a    (op_a),
    .op_b    (op_b),
`ifdef SPI_ALU_MASTER_ABORT_EN
    .abort   (abort),
    .aborted (aborted),
`endif
    .busy    (busy),
    .done    (done),
    .result  (result),
    .spi_if  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural ALU slave: samples mosi on sclk rise, drives miso on sclk fall.
  logic [67:0] cap;
  logic [31:0] sres;
  int          rx_cnt;
  int          tx_idx;

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge bus.sclk or negedge bus.sclk or posedge bus.nss) begin
    if (bus.nss === 1'b1) begin
      rx_cnt   = 0;
      tx_idx   = 0;
      bus.miso = 1'b0;
    end else if (bus.sclk === 1'b1) begin
      if (rx_cnt < 68) begin
        cap    = {cap[66:0], bus.mosi};
        rx_cnt = rx_cnt + 1;
        if (rx_cnt == 68) sres = alu(cap[67:64], cap[63:32], cap[31:0]);
      end
    end else begin
      if (rx_cnt == 68 && tx_idx < 32) begin
        bus.miso = sres[31 - tx_idx];
        tx_idx   = tx_idx + 1;
      end
    end
  end

  // Bus monitors: done pulses, mosi stability in the high phase, mosi idle low.
  int   done_cnt = 0;
  int   mosi_viol = 0;
  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  always @(negedge clock) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.sclk === 1'b1 && prev_sclk === 1'b1 && bus.mosi !== prev_mosi) mosi_viol <= mosi_viol + 1;
    if (bus.nss === 1'b1 && bus.mosi !== 1'b0) mosi_viol <= mosi_viol + 1;
    prev_sclk <= bus.sclk;
    prev_mosi <= bus.mosi;
  end

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    opcode = op;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 2000) begin
      @(negedge clock);
      cnt++;
    end
  endtask

  task automatic run_txn(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int cnt;
    issue(op, a, b);
    check({name, " busy after start"}, 68'(busy), 68'(1));
    wait_done(cnt);
    check({name, " latency"}, 68'(cnt), 68'(TXN_LEN));
    check({name, " result"}, 68'(result), 68'(exp));
    check({name, " busy at done"}, 68'(busy), 68'(0));
    check({name, " nss at done"}, 68'(bus.nss), 68'(1));
    check({name, " mosi sequence"}, cap, {op, a, b});
    @(negedge clock);
    check({name, " done width"}, 68'(done), 68'(0));
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cnt;
    int dc;

    vecs[0] = '{"add", 4'd0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
    vecs[1] = '{"sub", 4'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
    vecs[2] = '{"not", 4'd5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A};
    vecs[3] = '{"and", 4'd2, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030};
    vecs[4] = '{"or",  4'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[5] = '{"xor", 4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F};

    reset_n = 1'b0;
    start   = 1'b0;
    opcode  = 4'd0;
    op_a    = 32'h0;
    op_b    = 32'h0;
`ifdef SPI_ALU_MASTER_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("reset nss", 68'(bus.nss), 68'(1));
    check("reset sclk", 68'(bus.sclk), 68'(0));
    check("reset mosi", 68'(bus.mosi), 68'(0));
    check("reset busy", 68'(busy), 68'(0));
    check("reset done", 68'(done), 68'(0));
    check("reset result", 68'(result), 68'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // second start 100 clocks into a transfer is ignored
    dc = done_cnt;
    issue(4'd0, 32'h0000_0005, 32'h0000_0003);
    repeat (98) @(negedge clock);
    issue(4'd4, 32'h1111_1111, 32'h2222_2222);
    wait_done(cnt);
    check("busy-start result", 68'(result), 68'(32'h0000_0008));
    repeat (20) @(negedge clock);
    check("busy-start done count", 68'(done_cnt - dc), 68'(1));
    check("busy-start idle", 68'(busy), 68'(0));

    // start in the done cycle is ignored, the next cycle is accepted
    issue(4'd3, 32'h0000_00F0, 32'h0000_000F);
    wait_done(cnt);
    check("or result", 68'(result), 68'(32'h0000_00FF));
    opcode = 4'd0;
    op_a   = 32'h0000_0010;
    op_b   = 32'h0000_0020;
    start  = 1'b1;
    @(negedge clock);
    check("start on done ignored", 68'(busy), 68'(0));
    @(negedge clock);
    start = 1'b0;
    check("start after done accepted", 68'(busy), 68'(1));
    wait_done(cnt);
    check("post-done result", 68'(result), 68'(32'h0000_0030));
    @(negedge clock);

    // reset 300 clocks into a transfer
    dc = done_cnt;
    issue(4'd0, 32'h0000_0001, 32'h0000_0002);
    repeat (299) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid reset nss", 68'(bus.nss), 68'(1));
    check("mid reset busy", 68'(busy), 68'(0));
    check("mid reset result", 68'(result), 68'(0));
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (900) @(negedge clock);
    check("mid reset no done", 68'(done_cnt - dc), 68'(0));
    run_txn("xor after reset", 4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);

`ifdef SPI_ALU_MASTER_ABORT_EN
    dc = done_cnt;
    issue(4'd0, 32'h0000_0007, 32'h0000_0007);
    repeat (199) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort nss", 68'(bus.nss), 68'(1));
    check("abort sclk", 68'(bus.sclk), 68'(0));
    check("abort busy", 68'(busy), 68'(0));
    check("abort pulse", 68'(aborted), 68'(1));
    @(negedge clock);
    check("abort pulse width", 68'(aborted), 68'(0));
    repeat (900) @(negedge clock);
    check("abort no done", 68'(done_cnt - dc), 68'(0));
    check("abort result kept", 68'(result), 68'(32'hF00F_F00F));
`endif

    check("mosi stability", 68'(mosi_viol), 68'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_alu_master.md
SPI_ALU_MASTER -- requirements
Module: spi_alu_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clocks per SCLK half-period; legal values are 2 or more.
REQ-002 SHALL have port clock  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle transaction request.
REQ-005 SHALL have port opcode  input  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT.
REQ-006 SHALL have port op_a  input  32  operand A.
REQ-007 SHALL have port op_b  input  32  operand B.
REQ-008 SHALL have port busy  output  1  high while a transaction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-010 SHALL have port result  output  32  last received ALU result.
REQ-011 SHALL have port spi_if  modport spi_if.MASTER  -  drives sclk, mosi and nss, and samples miso.

Function
REQ-012 SHALL, on start while idle, latch opcode, op_a and op_b, and assert busy in the next cycle; start while busy SHALL be ignored.
REQ-013 SHALL use states IDLE, SETUP, SEND, GAP, RECV, FINISH; FINISH SHALL return to IDLE.
REQ-014 In SETUP, SHALL drive nss low with sclk low for CLK_DIV clocks before the first sclk rising edge.
REQ-015 In SEND, SHALL shift out 68 bits MSB-first: opcode[3:0], then op_a[31:0], then op_b[31:0].
REQ-016 Each SEND bit SHALL be CLK_DIV clocks with sclk low followed by CLK_DIV clocks with sclk high.
REQ-017 mosi SHALL change only while sclk is low, and SHALL be stable for the whole high phase.
REQ-018 In GAP, after the 68th bit, SHALL hold sclk low for 2*CLK_DIV clocks so the slave can execute; mosi SHALL be 0.
REQ-019 In RECV, SHALL generate 32 sclk periods with the same timing as SEND.
REQ-020 In RECV, SHALL sample miso in the clock cycle in which it drives sclk high, shifting MSB-first into a 32-bit register.
REQ-021 In FINISH, SHALL hold sclk low for CLK_DIV clocks, then drive nss high, copy the shift register to result, pulse done for 1 cycle, and deassert busy in that same cycle.
REQ-022 Total transaction length SHALL be CLK_DIV*(1+2*68+2+2*32+1) clocks from the first busy-high cycle to done; this is 816 clocks for CLK_DIV=4.
REQ-023 result SHALL hold its value until the next done pulse.
REQ-024 A start in the cycle done is high SHALL be ignored; a new start is accepted from the following cycle.
REQ-025 Bit and divider counters SHALL not wrap within a phase; each SHALL reset to 0 on every phase change.

Reset
REQ-026 While reset_n is low, SHALL force state IDLE, nss=1, sclk=0, mosi=0, busy=0, done=0 and result=0, independent of clock.
REQ-027 On reset_n assertion mid-transaction, SHALL abandon the transfer immediately with no done pulse; the slave resynchronises on nss high.

Configuration
REQ-028 With macro SPI_ALU_MASTER_ABORT_EN defined, SHALL add input port abort (1 bit).
REQ-029 With SPI_ALU_MASTER_ABORT_EN defined, abort high while busy SHALL, on the next clock, drive nss high, sclk low and mosi 0, return to IDLE, clear busy, pulse output port aborted for 1 cycle and leave result unchanged.
REQ-030 Without SPI_ALU_MASTER_ABORT_EN, ports abort and aborted SHALL not exist, and transactions SHALL always run to completion.

Verification
REQ-031 ADD: opcode 0, A=0x00000005, B=0x00000003 against the ALU slave -> done after 816 clocks (CLK_DIV=4), result=0x00000008.
REQ-032 SUB: opcode 1, A=0x00000003, B=0x00000005 -> result=0xFFFFFFFE; mosi bit sequence checked against 0001 followed by A then B.
REQ-033 NOT: opcode 5, A=0xA5A5A5A5, B=0xFFFFFFFF -> result=0x5A5A5A5A.
REQ-034 Second start pulse 100 clocks into a busy transaction -> ignored; exactly one done pulse; result matches the first request.
REQ-035 reset_n low at clock 300 of a transaction -> nss=1, busy=0, result=0, no done; a following XOR with A=0xFF00FF00, B=0x0F0F0F0F -> result=0xF00FF00F.
REQ-036 With SPI_ALU_MASTER_ABORT_EN defined, abort at clock 200 -> nss high in the next cycle, aborted pulses once, no done, result unchanged.
